// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction fetcher: widths, opcode fields,
// FSM state encoding and the instruction-queue entry layout.
package fetcher_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } fetchState_t;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
      logic              jumpFlag;
   } iqEntry_t;

   function automatic logic [6:0] opcodeOf(input logic [INST_W-1:0] inst);
      return inst[6:0];
   endfunction

endpackage

// File: rtl/fetcher_predictor.sv
// Static branch predictor: JAL always taken, backward branches taken,
// everything else falls through to pc + 4.
module static_predictor
   import fetcher_pkg::*;
(
   input  logic [INST_W-1:0] inst,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic              jump_flag
);

   logic [ADDR_W-1:0] w_jImm;
   logic [ADDR_W-1:0] w_bImm;

   assign w_jImm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   assign w_bImm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

   // JALR targets depend on a register value, so they are never predicted
   always_comb begin
      next_pc   = pc + ADDR_W'(4);
      jump_flag = 1'b0;
      case (opcodeOf(inst))
         OPC_JAL: begin
            next_pc   = pc + w_jImm;
            jump_flag = 1'b1;
         end
         OPC_BRANCH: begin
            if (inst[31]) begin
               next_pc   = pc + w_bImm;
               jump_flag = 1'b1;
            end
         end
         OPC_JALR: begin
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/fetcher.sv
// Instruction fetcher: issues one memory request at a time, predicts the next
// pc, buffers fetched words in a circular queue and feeds the decoder.
module fetcher
   import fetcher_pkg::*;
#(
   parameter int IQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   output logic              out_mem_valid,
   output logic [ADDR_W-1:0] out_mem_pc,
   input  logic              in_mem_done,
   input  logic [INST_W-1:0] in_mem_inst,
   output logic [INST_W-1:0] out_dcd_inst,
   output logic [ADDR_W-1:0] out_dcd_pc,
   output logic              out_dcd_jump_flag,
   input  logic              in_rob_full,
   input  logic              in_rs_full,
   input  logic              in_lsb_full,
   input  logic              in_rob_flush,
   input  logic [ADDR_W-1:0] in_rob_flush_pc
);

   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IQ_DEPTH);

   fetchState_t       r_state;
   fetchState_t       w_stateNext;
   logic [ADDR_W-1:0] r_pc;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   iqEntry_t          r_queue [IQ_DEPTH];
   iqEntry_t          w_headEntry;
   logic              w_stall;
   logic              w_issue;
   logic              w_enq;
   logic [ADDR_W-1:0] w_predPc;
   logic              w_predJump;

   static_predictor u_predictor (
      .inst      (in_mem_inst),
      .pc        (r_pc),
      .next_pc   (w_predPc),
      .jump_flag (w_predJump)
   );

   assign w_stall     = in_rob_full | in_rs_full | in_lsb_full;
   assign w_headEntry = r_queue[r_head];
   assign w_issue     = rdy && !in_rob_flush && (r_count != '0) && !w_stall;
   assign w_enq       = rdy && !in_rob_flush && (r_state == ST_WAIT) && in_mem_done;

   // A flush during an outstanding request parks in DISCARD so the stale
   // completion is swallowed instead of being queued under the new pc.
   always_comb begin
      w_stateNext = r_state;
      if (rdy) begin
         if (in_rob_flush) begin
            if ((r_state == ST_WAIT || r_state == ST_DISCARD) && !in_mem_done)
               w_stateNext = ST_DISCARD;
            else
               w_stateNext = ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE:    if (r_count < CNT_FULL) w_stateNext = ST_WAIT;
               ST_WAIT:    if (in_mem_done) w_stateNext = ST_IDLE;
               ST_DISCARD: if (in_mem_done) w_stateNext = ST_IDLE;
               default:    w_stateNext = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy) begin
         r_state <= w_stateNext;
         if (in_rob_flush) begin
            r_pc    <= in_rob_flush_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_enq) begin
               r_pc   <= w_predPc;
               r_tail <= r_tail + PTR_W'(1);
            end
            if (w_issue)
               r_head <= r_head + PTR_W'(1);
            case ({w_enq, w_issue})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Queue storage needs no reset: validity is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (w_enq)
         r_queue[r_tail] <= '{inst: in_mem_inst, pc: r_pc, jumpFlag: w_predJump};
   end

   assign out_mem_valid     = (r_state == ST_WAIT);
   assign out_mem_pc        = r_pc;
   assign out_dcd_inst      = w_issue ? w_headEntry.inst : '0;
   assign out_dcd_pc        = w_issue ? w_headEntry.pc : '0;
   assign out_dcd_jump_flag = w_issue ? w_headEntry.jumpFlag : 1'b0;

endmodule

// File: tb/tb_fetcher.sv
// Bench for the fetcher: a transaction-level queue model plus a latency-
// configurable memory responder, directed scenarios and a random phase.
module tb_fetcher;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        jf;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b0;
   logic        out_mem_valid;
   logic [31:0] out_mem_pc;
   logic        in_mem_done = 1'b0;
   logic [31:0] in_mem_inst = '0;
   logic [31:0] out_dcd_inst;
   logic [31:0] out_dcd_pc;
   logic        out_dcd_jump_flag;
   logic        in_rob_full = 1'b0;
   logic        in_rs_full = 1'b0;
   logic        in_lsb_full = 1'b0;
   logic        in_rob_flush = 1'b0;
   logic [31:0] in_rob_flush_pc = '0;

   ent_t        mQ[$];
   logic [31:0] mPc;
   bit          mBusy;
   bit          mDrop;
   int          memLeft;
   int          memLat;
   bit          randMem;
   logic [31:0] memImage [logic [31:0]];
   int          compared;
   int          mismatched;
   logic [31:0] obsDcdInst, obsDcdPc, obsMemPc;
   logic        obsDcdJf, obsMemValid;

   fetcher #(.IQ_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .rdy               (rdy),
      .out_mem_valid     (out_mem_valid),
      .out_mem_pc        (out_mem_pc),
      .in_mem_done       (in_mem_done),
      .in_mem_inst       (in_mem_inst),
      .out_dcd_inst      (out_dcd_inst),
      .out_dcd_pc        (out_dcd_pc),
      .out_dcd_jump_flag (out_dcd_jump_flag),
      .in_rob_full       (in_rob_full),
      .in_rs_full        (in_rs_full),
      .in_lsb_full       (in_lsb_full),
      .in_rob_flush      (in_rob_flush),
      .in_rob_flush_pc   (in_rob_flush_pc)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mkJal(input int off);
      logic [31:0] o;
      o = off;
      return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'h6F};
   endfunction

   function automatic logic [31:0] mkBeq(input int off);
      logic [31:0] o;
      o = off;
      return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'h63};
   endfunction

   function automatic logic [31:0] randInst();
      case ($urandom_range(0, 4))
         0:       return 32'h0000_0013;
         1:       return mkJal((int'($urandom_range(0, 2047)) - 1024) * 2);
         2:       return mkBeq((int'($urandom_range(0, 2047)) - 1024) * 2);
         3:       return 32'h0000_8067;
         default: return $urandom();
      endcase
   endfunction

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (memImage.exists(a))
         return memImage[a];
      if (randMem) begin
         memImage[a] = randInst();
         return memImage[a];
      end
      return 32'h0000_0013;
   endfunction

   // Static prediction worked out from the immediate value as a signed number
   function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                   output logic [31:0] nxt, output logic jf);
      logic [31:0] imm;
      nxt = pc + 32'd4;
      jf  = 1'b0;
      if (inst[6:0] == 7'h6F) begin
         imm = {11'd0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         if (inst[31]) imm = imm - 32'h0020_0000;
         nxt = pc + imm;
         jf  = 1'b1;
      end else if (inst[6:0] == 7'h63 && inst[31]) begin
         imm = {19'd0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} - 32'h0000_2000;
         nxt = pc + imm;
         jf  = 1'b1;
      end
   endfunction

   function automatic int memLatency();
      return (memLat > 0) ? memLat : int'($urandom_range(1, 3));
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, advance the model
   task automatic applyStimulus(input bit iRdy, input bit iStall, input bit iFlush,
                                input logic [31:0] iFlushPc, input bit iSpurious);
      logic [2:0]  st;
      bit          d, expIssue, wasBusy, newReq;
      int          nBefore;
      ent_t        e;
      logic [31:0] nxt;
      logic        jf;
      st = iStall ? 3'($urandom_range(1, 7)) : 3'b000;
      d  = (mBusy && memLeft == 1) || (!mBusy && iSpurious);
      rdy             = iRdy;
      in_rob_full     = st[0];
      in_rs_full      = st[1];
      in_lsb_full     = st[2];
      in_rob_flush    = iFlush;
      in_rob_flush_pc = iFlushPc;
      in_mem_done     = d;
      in_mem_inst     = (d && mBusy && !mDrop) ? memWord(mPc) : $urandom();
      #2;
      obsMemValid = out_mem_valid;
      obsMemPc    = out_mem_pc;
      obsDcdInst  = out_dcd_inst;
      obsDcdPc    = out_dcd_pc;
      obsDcdJf    = out_dcd_jump_flag;
      expIssue = iRdy && !iFlush && (mQ.size() > 0) && !iStall;
      checkOutput("mem_valid", {31'd0, out_mem_valid}, {31'd0, mBusy && !mDrop});
      if (mBusy && !mDrop)
         checkOutput("mem_pc", out_mem_pc, mPc);
      if (expIssue) begin
         checkOutput("dcd_inst", out_dcd_inst, mQ[0].inst);
         checkOutput("dcd_pc", out_dcd_pc, mQ[0].pc);
         checkOutput("dcd_jf", {31'd0, out_dcd_jump_flag}, {31'd0, mQ[0].jf});
      end else begin
         checkOutput("nop_inst", out_dcd_inst, 32'd0);
         checkOutput("nop_pc", out_dcd_pc, 32'd0);
         checkOutput("nop_jf", {31'd0, out_dcd_jump_flag}, 32'd0);
      end
      wasBusy = mBusy;
      newReq  = 1'b0;
      if (iRdy) begin
         nBefore = mQ.size();
         if (iFlush) begin
            mQ.delete();
            mPc = iFlushPc;
            if (mBusy && !d) mDrop = 1'b1;
            else if (mBusy) begin mBusy = 1'b0; mDrop = 1'b0; end
         end else begin
            if (expIssue) void'(mQ.pop_front());
            if (mBusy && d) begin
               if (!mDrop) begin
                  predict(in_mem_inst, mPc, nxt, jf);
                  e.inst = in_mem_inst;
                  e.pc   = mPc;
                  e.jf   = jf;
                  mQ.push_back(e);
                  mPc = nxt;
               end
               mBusy = 1'b0;
               mDrop = 1'b0;
            end else if (!mBusy && nBefore < DEPTH) begin
               mBusy  = 1'b1;
               newReq = 1'b1;
            end
         end
      end
      if (newReq || (wasBusy && d)) memLeft = memLatency();
      else if (wasBusy) memLeft--;
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rdy = 1'b1; in_mem_done = 1'b0; in_rob_flush = 1'b0;
      in_rob_full = 1'b0; in_rs_full = 1'b0; in_lsb_full = 1'b0;
      rst = 1'b1;
      #2;
      checkOutput("rst_mem_valid", {31'd0, out_mem_valid}, 32'd0);
      checkOutput("rst_mem_pc", out_mem_pc, 32'd0);
      checkOutput("rst_dcd_inst", out_dcd_inst, 32'd0);
      checkOutput("rst_dcd_pc", out_dcd_pc, 32'd0);
      checkOutput("rst_dcd_jf", {31'd0, out_dcd_jump_flag}, 32'd0);
      mQ.delete();
      mPc = '0; mBusy = 1'b0; mDrop = 1'b0; memLeft = 1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic waitIdle(input bit iStall);
      for (int n = 0; n < 20 && mBusy; n++)
         applyStimulus(1'b1, iStall, 1'b0, 32'd0, 1'b0);
      checkOutput("idle_reached", {31'd0, mBusy}, 32'd0);
   endtask

   task automatic flushTo(input logic [31:0] pc, input bit iStall);
      applyStimulus(1'b1, iStall, 1'b1, pc, 1'b0);
      waitIdle(iStall);
   endtask

   initial begin
      compared = 0; mismatched = 0; randMem = 1'b0; memLat = 3;
      @(posedge clk);
      #1;
      applyReset();

      // First fetch after reset, memory answers on the third WAIT cycle
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("first_inst", obsDcdInst, 32'h0000_0013);
      checkOutput("first_pc", obsDcdPc, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("second_req_pc", obsMemPc, 32'h4);

      // Taken JAL and not-taken forward branch
      memLat = 1;
      memImage[32'h10] = mkJal(-8);
      memImage[32'h20] = mkBeq(16);
      flushTo(32'h10, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("jal_jf", {31'd0, obsDcdJf}, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("jal_target", obsMemPc, 32'h8);
      flushTo(32'h20, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("beq_jf", {31'd0, obsDcdJf}, 32'd0);
      checkOutput("beq_inst", obsDcdInst, mkBeq(16));
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("beq_next", obsMemPc, 32'h24);

      // Stall fills the queue, release drains it in order
      flushTo(32'h200, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput("full_no_req", {31'd0, obsMemValid}, 32'd0);
      checkOutput("full_no_issue", obsDcdInst, 32'd0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
         checkOutput("drain_pc", obsDcdPc, 32'h200 + 32'(4 * k));
      end

      // Flush during WAIT drops the stale completion
      memLat = 3;
      flushTo(32'h80, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("flush_req_pc", obsMemPc, 32'h100);
      checkOutput("flush_q_empty", obsDcdInst, 32'd0);

      // Flush coinciding with a completion and an issue-eligible head
      memLat = 1;
      flushTo(32'h300, 1'b1);
      for (int n = 0; n < 20 && !(mBusy && memLeft == 1 && mQ.size() > 0); n++)
         applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
      checkOutput("coflush_no_issue", obsDcdInst, 32'd0);
      checkOutput("coflush_no_pc", obsDcdPc, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("coflush_idle", {31'd0, obsMemValid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("coflush_pc", obsMemPc, 32'h100);

      // Reset during WAIT, then a late completion while idle
      memLat = 3;
      waitIdle(1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      applyReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("late_done_pc", obsMemPc, 32'd0);
      checkOutput("late_done_nop", obsDcdInst, 32'd0);

      // Random traffic against the model
      memLat = 0;
      randMem = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 39) == 0), ($urandom() & 32'hFFFF_FFFC),
                       ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, meaning the instruction-queue entry count, restricted to powers of two of at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port rdy, input, 1 bit: global enable; when low, state SHALL hold.
REQ-005 SHALL have port out_mem_valid, output, 1 bit: instruction-fetch request.
REQ-006 SHALL have port out_mem_pc, output, 32 bits: fetch address.
REQ-007 SHALL have port in_mem_done, input, 1 bit: the fetch completed this cycle.
REQ-008 SHALL have port in_mem_inst, input, 32 bits: the fetched instruction word.
REQ-009 SHALL have ports out_dcd_inst (output, 32 bits), out_dcd_pc (output, 32 bits) and out_dcd_jump_flag (output, 1 bit): the decoder feed.
REQ-010 SHALL have ports in_rob_full, in_rs_full and in_lsb_full, inputs, 1 bit each: downstream stall.
REQ-011 SHALL have ports in_rob_flush (input, 1 bit) and in_rob_flush_pc (input, 32 bits): misprediction redirect.

Function
REQ-012 SHALL hold a fetch pc and a circular queue of {inst, pc, jump_flag} entries with head/tail pointers and a count.
REQ-013 FSM states SHALL be IDLE, WAIT and DISCARD.
- IDLE->WAIT: when count plus 0 < IQ_DEPTH and no flush; out_mem_valid=1 with out_mem_pc=pc while in WAIT.
- WAIT, on in_mem_done: enqueue, advance pc, return to IDLE.
REQ-014 On in_mem_done the fetcher SHALL apply static prediction to in_mem_inst.
- JAL: next pc = pc + J-imm, jump_flag=1.
- B-type with negative imm: next pc = pc + B-imm, jump_flag=1.
- B-type with non-negative imm: pc + 4, jump_flag=0.
- JALR and all others: pc + 4, jump_flag=0.
REQ-015 Immediates SHALL be sign-extended to 32 bits; address arithmetic SHALL wrap modulo 2^32.
REQ-016 Issue: each cycle with count>0 and none of the stall inputs set, the fetcher SHALL drive the head entry on out_dcd_* for exactly one cycle and pop it.
- Otherwise it SHALL drive out_dcd_inst=0 (decodes as NOP), out_dcd_pc=0 and out_dcd_jump_flag=0.
- Latency: in_mem_done at cycle T SHALL issue no earlier than T+1.
REQ-017 Enqueue and issue in the same cycle SHALL leave count unchanged; a new request SHALL NOT start while count == IQ_DEPTH.
REQ-018 Head/tail pointers SHALL wrap modulo IQ_DEPTH.
REQ-019 in_rob_flush SHALL take priority over all other events.
- The queue SHALL be emptied and pc set to in_rob_flush_pc.
- No issue SHALL occur in that cycle.
- From WAIT without same-cycle in_mem_done: go to DISCARD.
- Otherwise: go to IDLE.
REQ-020 DISCARD SHALL drop the pending in_mem_done without enqueueing, then go to IDLE; out_mem_valid SHALL be 0 in DISCARD.
REQ-021 A flush arriving while in DISCARD SHALL only update pc.
REQ-022 With rdy=0, all registers SHALL hold and the out_dcd_* outputs SHALL present a NOP.

Reset
REQ-023 While rst=1, asynchronously: pc=0, queue empty, pointers=0, state=IDLE, out_mem_valid=0, out_mem_pc=0, out_dcd_* = 0.
REQ-024 A mid-request reset SHALL abandon the request; a late in_mem_done arriving in IDLE SHALL be ignored.

Structure
REQ-025 Instruction/data widths, opcode and field ranges, and the FSM state encodings SHALL reside in definition.v.
REQ-026 Prediction and immediate extraction SHALL be a combinational sub-module named static_predictor (inputs inst and pc; outputs next_pc and jump_flag).

Verification
REQ-027 After reset, memory returns 0x00000013 at pc 0 with done after 3 cycles -> out_dcd_inst=0x00000013 and pc=0 one cycle later; the next request is at 0x4.
REQ-028 JAL x0,-8 fetched at 0x10 -> jump_flag=1; the next out_mem_pc is 0x8.
- BEQ with +16 at 0x20 -> jump_flag=0; next pc 0x24.
REQ-029 in_rs_full held for 10 cycles with single-cycle memory -> exactly 4 entries queued, out_mem_valid stays 0, and no issue occurs.
- On release: 4 consecutive issues, in order.
REQ-030 in_rob_flush with pc 0x100 while in WAIT -> the stale done is dropped; the next request is at 0x100 and the queue is empty.
REQ-031 Flush coincident with in_mem_done and with an issue-eligible head -> no enqueue, no issue; pc=0x100, state IDLE.
REQ-032 rst asserted mid-WAIT, then a late done -> no enqueue; pc=0 and outputs at 0.
